// File: rtl/riscv_core_pkg.sv
// Shared RV32IM core types: register/word types and the enums used by the write-back stage.
package riscv_core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_addr_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    STALL = 2'd2
  } wb_hold_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: shifts the raw memory word by the byte offset and
// sign/zero-extends according to funct3. Misaligned or reserved encodings are don't-care.
module load_align
  import riscv_core_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  word_t      data_i,
  output word_t      data_o
);

  word_t              shifted;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  assign shifted = data_i >> {addr_lo_i, 3'b000};
  assign b_s     = shifted[7:0];
  assign h_s     = shifted[15:0];

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      LB:      data_o = {{24{b_s[7]}}, b_s};
      LBU:     data_o = {24'b0, b_s};
      LH:      data_o = {{16{h_s[15]}}, h_s};
      LHU:     data_o = {16'b0, h_s};
      LW:      data_o = data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges the MEM/WB result with a one-entry divider holding register,
// with starvation stall and WAW kill. Optional same-cycle read bypass under WB_BYPASS_EN.
module wb_stage
  import riscv_core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pipe_valid_i,
  input  reg_addr_t  pipe_rd_i,
  input  logic       pipe_is_load_i,
  input  logic [2:0] pipe_funct3_i,
  input  logic [1:0] pipe_addr_lo_i,
  input  word_t      pipe_load_data_i,
  input  word_t      pipe_result_i,
  output logic       stall_o,
  input  logic       div_valid_i,
  output logic       div_ready_o,
  input  reg_addr_t  div_rd_i,
  input  word_t      div_result_i,
  output logic       write_en_o,
  output reg_addr_t  rd_addr_o,
  output word_t      rd_data_o
`ifdef WB_BYPASS_EN
  ,
  input  reg_addr_t  rs1_addr_i,
  input  reg_addr_t  rs2_addr_i,
  input  word_t      rf_rs1_data_i,
  input  word_t      rf_rs2_data_i,
  output word_t      rs1_data_o,
  output word_t      rs2_data_o
`endif
);

  wb_hold_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  reg_addr_t        hold_rd_q;
  word_t            hold_data_q;
  logic             capture;

  word_t     load_word, pipe_data;
  logic      pipe_wr;
  logic      wr_en_p0;
  reg_addr_t wr_addr_p0;
  word_t     wr_data_p0;

  load_align u_load_align (
    .funct3_i  (pipe_funct3_i),
    .addr_lo_i (pipe_addr_lo_i),
    .data_i    (pipe_load_data_i),
    .data_o    (load_word)
  );

  assign pipe_data   = pipe_is_load_i ? load_word : pipe_result_i;
  assign pipe_wr     = pipe_valid_i && (pipe_rd_i != '0) && (state_q != STALL);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign stall_o     = (state_q == STALL);
  assign div_ready_o = (state_q == EMPTY);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    wr_en_p0   = pipe_wr;
    wr_addr_p0 = pipe_rd_i;
    wr_data_p0 = pipe_data;
    case (state_q)
      EMPTY: begin
        // rd=0 results are dropped; a same-rd pipe write is younger, so the result is dead on arrival
        if (div_valid_i && (div_rd_i != '0)) begin
          if (!pipe_wr) begin
            wr_en_p0   = 1'b1;
            wr_addr_p0 = div_rd_i;
            wr_data_p0 = div_result_i;
          end else if (div_rd_i != pipe_rd_i) begin
            capture = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      end
      HELD: begin
        if (pipe_wr && (pipe_rd_i == hold_rd_q)) begin
          state_d = EMPTY;
          cnt_d   = '0;
        end else if (!pipe_wr) begin
          wr_en_p0   = 1'b1;
          wr_addr_p0 = hold_rd_q;
          wr_data_p0 = hold_data_q;
          state_d    = EMPTY;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(STARVE_LIMIT)) state_d = STALL;
        end
      end
      STALL: begin
        wr_en_p0   = 1'b1;
        wr_addr_p0 = hold_rd_q;
        wr_data_p0 = hold_data_q;
        state_d    = EMPTY;
        cnt_d      = '0;
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      hold_rd_q   <= div_rd_i;
      hold_data_q <= div_result_i;
    end
  end

  // ---- p0 -> register-file write port boundary ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      write_en_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else begin
      write_en_o <= wr_en_p0;
      if (wr_en_p0) begin
        rd_addr_o <= wr_addr_p0;
        rd_data_o <= wr_data_p0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_data_o = (write_en_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != '0))
                      ? rd_data_o : rf_rs1_data_i;
  assign rs2_data_o = (write_en_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != '0))
                      ? rd_data_o : rf_rs2_data_i;
`endif

  a_no_x0_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(write_en_o && (rd_addr_o == '0)));

endmodule
